// File: rtl/spi_cfg_master_pkg.sv
// Shared constants for the SPI configuration master: peripheral register map,
// frame layout and FSM state encoding.
package spi_cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
  localparam logic [6:0] MAX_ADDR       = 7'h04;

  localparam int   FRAME_W   = 16;
  localparam logic WRITE_BIT = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                     input logic [7:0] data);
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_cfg_master_if.sv
// Register-write request bus shared by the two on-chip requesters and the master.
interface spi_cfg_master_if;

  logic       req0_valid;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;

  logic       req1_valid;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready
  );

endinterface

// File: rtl/spi_cfg_master_frame_tx.sv
// Serialises one 16-bit SPI mode-0 frame: chip-select setup, 16 sclk periods,
// chip-select hold and an inter-frame gap.
module spi_frame_tx
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               sclk,
  output logic               ncs,
  output logic               copi,
  output logic               busy,
  output logic               done
);

  logic [2:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [4:0]         bit_q, bit_d;
  logic               phase_q, phase_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          sh_d    = frame;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 16'(CS_SETUP - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        // cnt_q is the half-period divider here; data moves only on the falling half
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
            sh_d    = {sh_q[FRAME_W-2:0], 1'b0};
          end else if (bit_q == 5'(FRAME_W - 1)) begin
            state_d = ST_HOLD;
          end else begin
            phase_d = 1'b1;
            bit_d   = bit_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 16'(CS_HOLD - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 16'(CS_GAP - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sh_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
    end
  end

  assign sclk = (state_q == ST_SHIFT) && phase_q;
  assign ncs  = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
  assign copi = sh_q[FRAME_W-1];
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: rtl/spi_cfg_master.sv
// Round-robin arbiter between two register-write requesters, address check,
// and SPI write-frame transmission to the register peripheral.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_cfg_master_if.slave  req,
  output logic             sclk,
  output logic             ncs,
  output logic             copi,
  output logic             busy,
  output logic             done,
  output logic             err
);

  logic               tx_busy;
  logic               grant0, grant1;
  logic               accept, addr_ok, start;
  logic [6:0]         sel_addr;
  logic [7:0]         sel_data;
  logic [FRAME_W-1:0] frame;
  logic               last_grant_q, last_grant_d;
  logic               err_q, err_d;

  // On a tie the requester not served last wins; ready is withheld during reset
  always_comb begin
    grant0 = req.req0_valid && (!req.req1_valid || last_grant_q);
    grant1 = req.req1_valid && (!req.req0_valid || !last_grant_q);
    req.req0_ready = rst_n && !tx_busy && grant0;
    req.req1_ready = rst_n && !tx_busy && grant1;
    accept   = req.req0_ready || req.req1_ready;
    sel_addr = req.req1_ready ? req.req1_addr : req.req0_addr;
    sel_data = req.req1_ready ? req.req1_data : req.req0_data;
    addr_ok  = (sel_addr <= MAX_ADDR);
    start    = accept && addr_ok;
    frame    = build_frame(sel_addr, sel_data);
    err_d    = accept && !addr_ok;
    last_grant_d = last_grant_q;
    if (req.req1_ready) begin
      last_grant_d = 1'b1;
    end else if (req.req0_ready) begin
      last_grant_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign err  = err_q;
  assign busy = tx_busy;

  spi_frame_tx #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .CS_GAP   (CS_GAP)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .frame (frame),
    .sclk  (sclk),
    .ncs   (ncs),
    .copi  (copi),
    .busy  (tx_busy),
    .done  (done)
  );

endmodule
